// File: rtl/pipeline_credit_fifo_if.sv
// Handshake bundle between the credit FIFO, the upstream producer, the stitched
// pipeline's last stage and the downstream consumer.
interface pipeline_credit_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  up_valid;
   logic                  up_ready;
   logic                  pipe_in_valid;
   logic                  pipe_out_valid;
   logic [DATA_WIDTH-1:0] pipe_out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  err;

   modport master (
      output up_valid, pipe_out_valid, pipe_out_data, out_ready,
      input  up_ready, pipe_in_valid, out_valid, out_data, err
   );

   modport slave (
      input  up_valid, pipe_out_valid, pipe_out_data, out_ready,
      output up_ready, pipe_in_valid, out_valid, out_data, err
   );
endinterface

// File: rtl/pipeline_credit_fifo.sv
// Credit-gated output FIFO for a non-stallable valid pipeline: upstream is admitted
// only when a FIFO slot is guaranteed for the item once it leaves the pipeline.
module pipeline_credit_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int LATENCY    = 3
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_credit_fifo_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   if (DEPTH < 1 || LATENCY < 1) begin : g_param_check
      $error("pipeline_credit_fifo: DEPTH and LATENCY must both be at least 1");
   end

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [CW-1:0]         reserved_r;
   logic [CW-1:0]         count_r;
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic                  up_ready_r;
   logic                  out_valid_r;
   logic                  err_r;

   logic                  acc_s;
   logic                  pop_s;
   logic                  write_s;
   logic                  overflow_s;
   logic                  phantom_s;
   logic [CW-1:0]         reserved_next_s;
   logic [CW-1:0]         count_next_s;

   // Circular pointer advance that also wraps for non-power-of-2 depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == LAST_PTR) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   // Handshake decode, protocol-violation detection and next-state arithmetic.
   always_comb begin
      acc_s           = bus.up_valid & up_ready_r;
      pop_s           = out_valid_r & bus.out_ready;
      overflow_s      = bus.pipe_out_valid & (count_r == DEPTH_C) & ~pop_s;
      phantom_s       = bus.pipe_out_valid & (reserved_r == count_r);
      write_s         = bus.pipe_out_valid & ~overflow_s;
      reserved_next_s = reserved_r;
      count_next_s    = count_r;

      // A pop of a phantom item must not wrap the credit counter below zero.
      case ({acc_s, pop_s})
         2'b10: reserved_next_s = reserved_r + CW'(1);
         2'b01: begin
            if (reserved_r != {CW{1'b0}}) begin
               reserved_next_s = reserved_r - CW'(1);
            end else begin
               reserved_next_s = reserved_r;
            end
         end
         default: reserved_next_s = reserved_r;
      endcase

      case ({write_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Credit, occupancy, pointer and sticky error registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reserved_r  <= {CW{1'b0}};
         count_r     <= {CW{1'b0}};
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         up_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         reserved_r  <= reserved_next_s;
         up_ready_r  <= (reserved_next_s < DEPTH_C);
         count_r     <= count_next_s;
         out_valid_r <= (count_next_s != {CW{1'b0}});
         if (write_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         if (overflow_s | phantom_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (write_s) begin
         mem_r[wr_ptr_r] <= bus.pipe_out_data;
      end
   end

   assign bus.up_ready      = up_ready_r;
   assign bus.pipe_in_valid = acc_s;
   assign bus.out_valid     = out_valid_r;
   assign bus.out_data      = mem_r[rd_ptr_r];
   assign bus.err           = err_r;
endmodule

// File: doc/pipeline_credit_fifo.md
# pipeline_credit_fifo

Credit-based output buffer for a stitched, non-stallable valid pipeline. It tracks how many items are in flight and grants upstream admission only when a FIFO slot is guaranteed, so the pipeline can never overflow. It accepts the pipeline's final-stage registered `out` and valid, and presents a ready/valid stream to the downstream consumer. It sits directly after the last pipeline register.

## Interface
- `DATA_WIDTH`, default 32: width of the pipeline output word.
- `DEPTH`, default 4: number of FIFO entries and number of credits. Legal range is DEPTH ≥ 1. Full throughput requires DEPTH ≥ LATENCY+2.
- `LATENCY`, default 3: pipeline stage count. Used only by the LATENCY-dependent DEPTH rule above; no RTL logic depends on it.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronous to `clk` at the source.
- `up_valid` in 1: producer requests to inject an item.
- `up_ready` out 1: a credit is available. Registered.
- `pipe_in_valid` out 1: drives the pipeline's `in_valid`; equals `up_valid & up_ready`.
- `pipe_out_valid` in 1: valid of the pipeline's last stage.
- `pipe_out_data` in DATA_WIDTH: the pipeline's last-stage `out`.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts.
- `out_data` out DATA_WIDTH: head of FIFO, first-word fall-through.
- `err` out 1: sticky protocol-violation flag.

## Operation
- Accept: `acc = up_valid & up_ready`.
- Pop: `pop = out_valid & out_ready`.
- Push: `push = pipe_out_valid`.
- `reserved` counter, $clog2(DEPTH+1) bits, counts items in flight plus items stored.
  - +1 on acc, −1 on pop; both in the same cycle leaves it unchanged.
- `up_ready` register, next value = (reserved_next < DEPTH). It never depends combinationally on `out_ready` or `up_valid`.
- FIFO storage:
  - DEPTH-entry circular buffer.
  - Pointers `wr_ptr` and `rd_ptr` wrap from DEPTH−1 to 0, including non-power-of-2 DEPTH.
  - `count` has $clog2(DEPTH+1) bits.
  - push writes `mem[wr_ptr]`. pop advances `rd_ptr`. Push and pop in the same cycle leave `count` unchanged.
  - Push into an empty FIFO with a simultaneous pop is impossible: `out_valid` is 0 when empty, and there is no bypass.
- `out_valid` = (count != 0). `out_data` = `mem[rd_ptr]`. `out_data` is don't-care when `out_valid` = 0, and is held stable while `out_valid & !out_ready`.
- Order is strictly FIFO. Data is never modified.
- `err` sets on either violation and stays set until reset:
  - push when `count == DEPTH` and no pop in that cycle: overflow. The write is dropped; the FIFO is unchanged.
  - push when `reserved` counts no outstanding in-flight item, i.e. `reserved == count`: phantom item. The item is still stored if space exists.

## Timing
- Reset values, while `rst` = 0:
  - `up_ready` = 0, `out_valid` = 0, `err` = 0
  - `reserved` = 0, `count` = 0, both pointers 0
  - `pipe_in_valid` = 0
  - memory contents are not reset.
- First rising edge after `rst` deasserts: `up_ready` → 1 (DEPTH ≥ 1).
- Mid-operation reset discards all stored and in-flight items. The pipeline is reset by the same `rst`.
- Push at edge E makes `out_valid` = 1 in the cycle after E; minimum store latency is 1 cycle.
- Round trip with an always-ready consumer:
  - accept in cycle t
  - `pipe_out_valid` in cycle t+LATENCY
  - `out_valid` in cycle t+LATENCY+1, pop in that cycle
  - the credit is visible in `up_ready` in cycle t+LATENCY+2.
- When `reserved` = DEPTH−1 and accept and pop happen together, `up_ready` stays 1.
- When `reserved` = DEPTH, `up_ready` = 0. A pop makes it 1 in the next cycle.

## Test plan
1. **Reset.** Hold `rst` = 0 for 3 cycles with `up_valid` = 1 → `up_ready` = 0, `out_valid` = 0, `pipe_in_valid` = 0, `err` = 0. After release, `up_ready` = 1 at the first edge.
2. **Single item** (DEPTH=4, LATENCY=3, pipeline model out = x+2). Accept x=0x10 in cycle 0 with `out_ready` = 1 → `pipe_out_valid` in cycle 3, `out_valid` in cycle 4 with `out_data` = 0x12, popped; `reserved` returns to 0.
3. **Backpressure.** `out_ready` = 0, `up_valid` = 1 continuously → exactly 4 accepts, then `up_ready` = 0 and FIFO holds 4 items, `err` = 0. Raise `out_ready` → 4 items drain in order; `up_ready` = 1 the cycle after the first pop.
4. **Throughput and wrap.** DEPTH=5, LATENCY=3, `out_ready` = 1, `up_valid` = 1 for 100 cycles → `up_ready` never drops, 100 items out in order, pointers wrap 20 times.
5. **Boundary.** `reserved` = 3 (DEPTH=4), then accept and pop in the same cycle → `reserved` stays 3 and `up_ready` stays 1. Random `out_ready` over 1000 items → no loss, no reordering, `err` = 0.
6. **Violations.**
   - Force `pipe_out_valid` with `reserved` = 0 → `err` = 1 next cycle, and still 1 after 10 more cycles.
   - Force an extra push into a full FIFO with no pop → FIFO contents unchanged and `err` = 1.
   - Pulse `rst` low → `err` = 0 and FIFO empty.
